// File: rtl/spc_stack_ctl_if.sv
// rtl/spc_stack_ctl_if.sv - spy/debug bus shared with SPC stack RAM port B
interface spc_stack_ctl_if #(
  parameter int AW = 5,
  parameter int DW = 19
) ();
  logic          dbg_req;
  logic          dbg_we;
  logic          dbg_ptr;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;

  modport master (
    output dbg_req, dbg_we, dbg_ptr, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_ptr, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata
  );
endinterface

// File: rtl/spc_stack_ctl.sv
// rtl/spc_stack_ctl.sv - SPC return stack pointer/depth control with shared debug port
module spc_stack_ctl #(
  parameter int AW         = 5,
  parameter int DW         = 19,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic          seq_stall,
  output logic [AW-1:0] spcptr,
  output logic          ovf,
  output logic          unf,
  output logic          err_both,
  input  logic          err_clr,
  spc_stack_ctl_if.slave dbg,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_data_a,
  output logic          ram_wren_a,
  output logic          ram_rden_a,
  input  logic [DW-1:0] ram_q_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_b,
  output logic          ram_wren_b,
  output logic          ram_rden_b,
  input  logic [DW-1:0] ram_q_b
);
  localparam int            CW       = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL     = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   DEPTH_1  = 1;
  localparam logic [AW-1:0] PTR_1    = 1;
  localparam logic [CW-1:0] CNT_1    = 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_MAX);

  typedef enum logic [1:0] {D_IDLE, D_RD, D_ACK, D_WAIT} dstate_t;

  dstate_t       dstate, dstate_nx;
  logic [AW:0]   depth;
  logic [CW-1:0] starve_cnt;
  logic [DW-1:0] rdata_q;
  logic          dbg_pend, seq_req, issue, blocked;
  logic          do_push, do_pop, both;

  // A pending request waits for a sequencer-idle cycle or forces one via seq_stall.
  assign dbg_pend  = !reset && dstate == D_IDLE && dbg.dbg_req;
  assign seq_req   = push | pop;
  assign seq_stall = dbg_pend && starve_cnt == CNT_MAX;
  assign issue     = dbg_pend && (!seq_req || seq_stall);
  assign blocked   = dbg_pend && seq_req && !seq_stall;
  assign do_push   = !reset && push && !seq_stall;
  assign do_pop    = !reset && pop && !push && !seq_stall;
  assign both      = !reset && push && pop && !seq_stall;

  assign ram_wren_a = do_push;
  assign ram_rden_a = do_pop;
  assign ram_addr_a = do_push ? spcptr + PTR_1 : spcptr;
  assign ram_data_a = push_data;
  assign pop_data   = ram_q_a;
  assign ram_addr_b = dbg.dbg_addr;
  assign ram_data_b = dbg.dbg_wdata;
  assign dbg.dbg_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) dstate <= D_IDLE;
    else       dstate <= dstate_nx;
  end

  always_comb begin
    dstate_nx   = dstate;
    dbg.dbg_ack = 1'b0;
    ram_wren_b  = 1'b0;
    ram_rden_b  = 1'b0;
    case (dstate)
      D_IDLE: if (issue) begin
        ram_wren_b = !dbg.dbg_ptr && dbg.dbg_we;
        ram_rden_b = !dbg.dbg_ptr && !dbg.dbg_we;
        dstate_nx  = (!dbg.dbg_ptr && !dbg.dbg_we) ? D_RD : D_ACK;
      end
      D_RD:   dstate_nx = D_ACK;
      D_ACK: begin
        dbg.dbg_ack = !reset;
        dstate_nx   = D_WAIT;
      end
      D_WAIT: if (!dbg.dbg_req) dstate_nx = D_IDLE;
      default: dstate_nx = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spcptr     <= '0;
      depth      <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      err_both   <= 1'b0;
      pop_valid  <= 1'b0;
      starve_cnt <= '0;
      rdata_q    <= '0;
    end else begin
      pop_valid <= do_pop;
      if (issue)        starve_cnt <= '0;
      else if (blocked) starve_cnt <= starve_cnt + CNT_1;

      if (issue && dbg.dbg_ptr && dbg.dbg_we) begin
        spcptr <= dbg.dbg_wdata[AW-1:0];
        depth  <= '0;
      end else if (do_push) begin
        spcptr <= spcptr + PTR_1;
        if (depth != FULL) depth <= depth + DEPTH_1;
      end else if (do_pop) begin
        spcptr <= spcptr - PTR_1;
        if (depth != '0) depth <= depth - DEPTH_1;
      end

      if (err_clr) begin
        ovf      <= 1'b0;
        unf      <= 1'b0;
        err_both <= 1'b0;
      end else begin
        if (do_push && depth == FULL) ovf <= 1'b1;
        if (do_pop && depth == '0)    unf <= 1'b1;
        if (both)                     err_both <= 1'b1;
      end

      if (issue && dbg.dbg_ptr && !dbg.dbg_we) rdata_q <= DW'(spcptr);
      else if (dstate == D_RD)                 rdata_q <= ram_q_b;
    end
  end
endmodule
